// File: rtl/exception_sequencer.sv
// exception_sequencer: steps the CPSR/SPSR register block through exception
// entry (FIQ, IRQ, undefined instruction, SWI) and exception return, and
// issues the vector PC load to fetch. All outputs are registered.
//
// Optional build macro EXC_HIVECS_EN: adds input hivecs; when it is sampled
// high together with the cause, vectors are based at 32'hFFFF0000 instead
// of VEC_BASE.
//
// state  | meaning
// IDLE   | waiting for an eligible source at an instruction boundary
// SAVE   | SPSR <= CPSR, banked LR captures the return address
// SWITCH | CPSR switched to the target mode
// VECTOR | fetch loads the vector address, entry acknowledged
// RET    | CPSR restored from SPSR, return acknowledged
module exception_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000,
  parameter logic [4:0]  USR_MODE = 5'b10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fiq,
  input  logic        irq,
  input  logic        und_req,
  input  logic        swi_req,
  input  logic        eret_req,
  input  logic        instr_boundary,
  input  logic        cpsr_f,
  input  logic        cpsr_i,
  input  logic [4:0]  cpsr_mode,
`ifdef EXC_HIVECS_EN
  input  logic        hivecs,
`endif
  output logic [2:0]  change_m,
  output logic        w_spsr_s,
  output logic        write_spsr,
  output logic [2:0]  w_cpsr_s,
  output logic        write_cpsr,
  output logic        pc_load,
  output logic [31:0] pc_vector,
  output logic        lr_write,
  output logic        exc_ack,
  output logic        eret_ack,
  output logic        eret_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SAVE, SWITCH, VECTOR, RET} state_t;

  // cause encoding, also the priority order
  localparam logic [1:0] C_FIQ = 2'd0;
  localparam logic [1:0] C_IRQ = 2'd1;
  localparam logic [1:0] C_UND = 2'd2;
  localparam logic [1:0] C_SWI = 2'd3;

  state_t      state;
  logic [1:0]  cause_q;
  logic [1:0]  win_cause;
  logic        exc_any;
  logic [31:0] vec_base;

  function automatic logic [2:0] mode_of(input logic [1:0] c);
    case (c)
      C_FIQ:   mode_of = 3'd1;
      C_IRQ:   mode_of = 3'd2;
      C_UND:   mode_of = 3'd4;
      default: mode_of = 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] cpsr_code_of(input logic [1:0] c);
    case (c)
      C_FIQ:   cpsr_code_of = 3'd3;
      C_IRQ:   cpsr_code_of = 3'd2;
      C_UND:   cpsr_code_of = 3'd5;
      default: cpsr_code_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] offset_of(input logic [1:0] c);
    case (c)
      C_FIQ:   offset_of = 32'h0000_001C;
      C_IRQ:   offset_of = 32'h0000_0018;
      C_UND:   offset_of = 32'h0000_0004;
      default: offset_of = 32'h0000_0008;
    endcase
  endfunction

`ifdef EXC_HIVECS_EN
  logic hivecs_q;

  // vector base chosen by hivecs as sampled with the cause
  always_ff @(posedge clk) begin
    if (rst)
      hivecs_q <= 1'b0;
    else if (state == IDLE && instr_boundary && !eret_err && exc_any)
      hivecs_q <= hivecs;
  end

  assign vec_base = hivecs_q ? 32'hFFFF_0000 : VEC_BASE;
`else
  assign vec_base = VEC_BASE;
`endif

  // priority arbitration of the eligible sources: fiq > irq > und > swi
  always_comb begin
    exc_any   = 1'b1;
    win_cause = C_SWI;
    if (fiq && !cpsr_f)
      win_cause = C_FIQ;
    else if (irq && !cpsr_i)
      win_cause = C_IRQ;
    else if (und_req)
      win_cause = C_UND;
    else if (swi_req)
      win_cause = C_SWI;
    else
      exc_any = 1'b0;
  end

  // sequencer state and registered strobes; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cause_q    <= C_FIQ;
      change_m   <= 3'd0;
      w_spsr_s   <= 1'b0;
      write_spsr <= 1'b0;
      w_cpsr_s   <= 3'd0;
      write_cpsr <= 1'b0;
      pc_load    <= 1'b0;
      pc_vector  <= 32'd0;
      lr_write   <= 1'b0;
      exc_ack    <= 1'b0;
      eret_ack   <= 1'b0;
      eret_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      write_spsr <= 1'b0;
      write_cpsr <= 1'b0;
      pc_load    <= 1'b0;
      lr_write   <= 1'b0;
      exc_ack    <= 1'b0;
      eret_ack   <= 1'b0;
      eret_err   <= 1'b0;
      w_spsr_s   <= 1'b0;
      case (state)
        IDLE: begin
          // an eret_err pulse in flight counts as the separating IDLE cycle,
          // so a still-held eret_req is not rejected twice
          if (instr_boundary && !eret_err) begin
            if (exc_any) begin
              state      <= SAVE;
              cause_q    <= win_cause;
              change_m   <= mode_of(win_cause);
              w_spsr_s   <= 1'b1;
              write_spsr <= 1'b1;
              lr_write   <= 1'b1;
              busy       <= 1'b1;
            end else if (eret_req) begin
              if (cpsr_mode == USR_MODE) begin
                eret_err <= 1'b1;
              end else begin
                state      <= RET;
                change_m   <= 3'd0;
                w_cpsr_s   <= 3'd0;
                write_cpsr <= 1'b1;
                eret_ack   <= 1'b1;
                busy       <= 1'b1;
              end
            end
          end
        end
        SAVE: begin
          state      <= SWITCH;
          w_cpsr_s   <= cpsr_code_of(cause_q);
          write_cpsr <= 1'b1;
        end
        SWITCH: begin
          state     <= VECTOR;
          pc_load   <= 1'b1;
          pc_vector <= vec_base + offset_of(cause_q);
          exc_ack   <= 1'b1;
        end
        VECTOR: begin
          state    <= IDLE;
          change_m <= 3'd0;
          w_cpsr_s <= 3'd0;
          busy     <= 1'b0;
        end
        RET: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          change_m <= 3'd0;
          w_cpsr_s <= 3'd0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
